// File: rtl/input_mon_pkg.sv
// input_mon_pkg: shared defaults, channel index type and parameter sanity check for input_monitor
package input_mon_pkg;

    localparam int unsigned N_DEF        = 61;
    localparam int unsigned DEBOUNCE_DEF = 1000;
    localparam int unsigned CNT_W_DEF    = 16;

    typedef logic [$clog2(N_DEF)-1:0] chan_idx_t;

    function automatic bit params_ok(input int unsigned n, input int unsigned d);
        return (n >= 1) && (d >= 1);
    endfunction

endpackage

// File: rtl/input_mon_chan.sv
// input_mon_chan: per-channel synchroniser, debounce counter, debounced state and edge pulses
module input_mon_chan
    import input_mon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter logic        INIT_BIT        = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_d_o
);

    localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q, s_q, state_q, rise_q, fall_q;
    logic          state_d, accept;
    logic [CW-1:0] cnt_q, cnt_d;

    // A differing level is accepted after DEBOUNCE_CYCLES stable cycles; returning to state restarts the count
    always_comb begin
        accept  = (s_q != state_q) && (cnt_q == LAST);
        cnt_d   = (s_q == state_q || accept) ? '0 : cnt_q + 1'b1;
        state_d = accept ? s_q : state_q;
    end

    // Two-flop synchroniser, debounce state and one-cycle edge pulses; reset discards any pending change
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= INIT_BIT;
            s_q     <= INIT_BIT;
            state_q <= INIT_BIT;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= din_i;
            s_q     <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= accept & s_q;
            fall_q  <= accept & ~s_q;
        end
    end

    assign state_o  = state_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign edge_d_o = accept;

endmodule

// File: rtl/input_monitor.sv
// input_monitor: N-channel debounced input conditioner with sticky change flags, event counter, matcher and test point
module input_monitor
    import input_mon_pkg::*;
#(
    parameter int unsigned    N               = N_DEF,
    parameter int unsigned    DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter logic [N-1:0]   INIT_VAL        = '0,
    parameter int unsigned    CNT_W           = CNT_W_DEF,
    parameter int unsigned    SEL_W           = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CLK_100M,
    input  logic             RST,
    input  logic [N-1:0]     din,
    input  logic             clear,
    input  logic [N-1:0]     match_pattern,
    input  logic [N-1:0]     match_mask,
    input  logic [SEL_W-1:0] tp_sel,
    output logic [N-1:0]     state,
    output logic [N-1:0]     rise,
    output logic [N-1:0]     fall,
    output logic [N-1:0]     changed,
    output logic             any_change,
    output logic [CNT_W-1:0] event_count,
    output logic             match,
    output logic             tp_out
);

    localparam int unsigned TPW = 2 ** SEL_W;

    if (!params_ok(N, DEBOUNCE_CYCLES)) begin : g_param_check
        $error("input_monitor: N and DEBOUNCE_CYCLES must both be at least 1");
    end

    logic [N-1:0]     state_w, rise_w, fall_w, edge_d;
    logic [N-1:0]     changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             any_q, match_q, match_d, match_init, tp_q, tp_d, tp_init, any_edge;
    logic [TPW-1:0]   tp_vec, tp_init_vec;

    for (genvar i = 0; i < N; i++) begin : g_chan
        input_mon_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT_BIT        (INIT_VAL[i])
        ) u_chan (
            .clk_i    (CLK_100M),
            .rst_i    (RST),
            .din_i    (din[i]),
            .state_o  (state_w[i]),
            .rise_o   (rise_w[i]),
            .fall_o   (fall_w[i]),
            .edge_d_o (edge_d[i])
        );
    end

    // Edge-driven next state uses the channels' pre-register edge so flags and count land with the pulse;
    // the select vector is zero-padded so out-of-range indices read 0
    always_comb begin
        any_edge    = |edge_d;
        changed_d   = (clear ? '0 : changed_q) | edge_d;
        cnt_d       = clear ? CNT_W'(any_edge) : (any_edge && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        match_d     = ((state_w ^ match_pattern) & match_mask) == '0;
        match_init  = ((INIT_VAL ^ match_pattern) & match_mask) == '0;
        tp_vec      = TPW'(state_w);
        tp_init_vec = TPW'(INIT_VAL);
        tp_d        = tp_vec[tp_sel];
        tp_init     = tp_init_vec[tp_sel];
    end

    // Sticky flags, saturating event counter and registered matcher / test point
    always_ff @(posedge CLK_100M) begin
        if (RST) begin
            changed_q <= '0;
            any_q     <= 1'b0;
            cnt_q     <= '0;
            match_q   <= match_init;
            tp_q      <= tp_init;
        end else begin
            changed_q <= changed_d;
            any_q     <= |changed_q;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            tp_q      <= tp_d;
        end
    end

    assign state       = state_w;
    assign rise        = rise_w;
    assign fall        = fall_w;
    assign changed     = changed_q;
    assign any_change  = any_q;
    assign event_count = cnt_q;
    assign match       = match_q;
    assign tp_out      = tp_q;

endmodule

// File: tb/tb_input_monitor.sv
// tb_input_monitor: directed scenario tests for input_monitor with DEBOUNCE_CYCLES=4 and CNT_W=4
module tb_input_monitor;

    localparam int N = 61;
    localparam int D = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  din, match_pattern, match_mask;
    logic          clear;
    logic [5:0]    tp_sel;
    logic [N-1:0]  state, rise, fall, changed;
    logic          any_change, match, tp_out;
    logic [CW-1:0] event_count;

    int n_cmp = 0;
    int n_err = 0;

    input_monitor #(
        .N               (N),
        .DEBOUNCE_CYCLES (D),
        .INIT_VAL        ('0),
        .CNT_W           (CW),
        .SEL_W           (6)
    ) dut (
        .CLK_100M      (clk),
        .RST           (rst),
        .din           (din),
        .clear         (clear),
        .match_pattern (match_pattern),
        .match_mask    (match_mask),
        .tp_sel        (tp_sel),
        .state         (state),
        .rise          (rise),
        .fall          (fall),
        .changed       (changed),
        .any_change    (any_change),
        .event_count   (event_count),
        .match         (match),
        .tp_out        (tp_out)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] bit_n(input int b);
        return N'(1) << b;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; din = '0; clear = 1'b0;
        match_pattern = '0; match_mask = '0; tp_sel = '0;
        tick(3);
        rst = 1'b0;
        tick(10);
        n_cmp++; if (state !== '0) begin n_err++; $display("FAIL reset_state: got %h want 0", state); end
        n_cmp++; if ((rise | fall) !== '0) begin n_err++; $display("FAIL reset_edges: got %h want 0", rise | fall); end
        n_cmp++; if (event_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", event_count); end
        n_cmp++; if (changed !== '0 || any_change !== 1'b0) begin n_err++; $display("FAIL reset_changed: got %h/%b want 0/0", changed, any_change); end
        n_cmp++; if (match !== 1'b1) begin n_err++; $display("FAIL reset_match: got %b want 1", match); end
    endtask

    task automatic test_rise;
        din[3] = 1'b1;
        tick(5);
        n_cmp++; if (rise !== '0 || state[3] !== 1'b0) begin n_err++; $display("FAIL rise_early: got rise %h state3 %b want 0/0", rise, state[3]); end
        tick(1);
        n_cmp++; if (rise !== bit_n(3)) begin n_err++; $display("FAIL rise_pulse: got %h want %h", rise, bit_n(3)); end
        n_cmp++; if (state[3] !== 1'b1 || changed !== bit_n(3)) begin n_err++; $display("FAIL rise_state: got state3 %b changed %h want 1/%h", state[3], changed, bit_n(3)); end
        n_cmp++; if (event_count !== 4'd1 || any_change !== 1'b0) begin n_err++; $display("FAIL rise_count: got %0d any %b want 1/0", event_count, any_change); end
        tick(1);
        n_cmp++; if (rise !== '0 || any_change !== 1'b1) begin n_err++; $display("FAIL rise_width: got rise %h any %b want 0/1", rise, any_change); end
    endtask

    task automatic test_fall;
        din[3] = 1'b0;
        tick(6);
        n_cmp++; if (fall !== bit_n(3) || rise !== '0 || state[3] !== 1'b0) begin n_err++; $display("FAIL fall_pulse: got fall %h rise %h state3 %b", fall, rise, state[3]); end
        n_cmp++; if (event_count !== 4'd2 || changed !== bit_n(3)) begin n_err++; $display("FAIL fall_count: got %0d changed %h want 2/%h", event_count, changed, bit_n(3)); end
    endtask

    task automatic test_glitch;
        logic saw = 1'b0;
        din[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(1); saw |= rise[3]; end
        din[3] = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(1); saw |= rise[3]; end
        n_cmp++; if (saw !== 1'b0 || state[3] !== 1'b0) begin n_err++; $display("FAIL glitch_rise: got saw %b state3 %b want 0/0", saw, state[3]); end
        n_cmp++; if (event_count !== 4'd2 || changed !== bit_n(3)) begin n_err++; $display("FAIL glitch_count: got %0d changed %h want 2/%h", event_count, changed, bit_n(3)); end
    endtask

    task automatic test_multi;
        logic [N-1:0] exp;
        exp = bit_n(0) | bit_n(5) | bit_n(60);
        din = exp;
        tick(6);
        n_cmp++; if (rise !== exp) begin n_err++; $display("FAIL multi_rise: got %h want %h", rise, exp); end
        n_cmp++; if (event_count !== 4'd3) begin n_err++; $display("FAIL multi_count: got %0d want 3", event_count); end
        n_cmp++; if (changed !== (exp | bit_n(3))) begin n_err++; $display("FAIL multi_changed: got %h want %h", changed, exp | bit_n(3)); end
    endtask

    task automatic test_clear_edge;
        din[1] = 1'b1;
        tick(5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_cmp++; if (changed !== bit_n(1) || rise !== bit_n(1)) begin n_err++; $display("FAIL clr_edge_changed: got %h rise %h want %h", changed, rise, bit_n(1)); end
        n_cmp++; if (event_count !== 4'd1) begin n_err++; $display("FAIL clr_edge_count: got %0d want 1", event_count); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_cmp++; if (changed !== '0 || event_count !== 4'd0 || any_change !== 1'b1) begin n_err++; $display("FAIL clr_plain: got %h %0d any %b want 0/0/1", changed, event_count, any_change); end
        tick(1);
        n_cmp++; if (any_change !== 1'b0) begin n_err++; $display("FAIL clr_any: got %b want 0", any_change); end
    endtask

    task automatic test_match;
        din[0] = 1'b0;
        tick(6);
        n_cmp++; if (fall !== bit_n(0) || state[1:0] !== 2'b10) begin n_err++; $display("FAIL match_setup: got fall %h state %b", fall, state[1:0]); end
        match_mask = N'(3); match_pattern = N'(1);
        tick(1);
        n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL match_miss: got %b want 0", match); end
        match_pattern = N'(2);
        n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL match_latency: got %b want 0", match); end
        tick(1);
        n_cmp++; if (match !== 1'b1) begin n_err++; $display("FAIL match_hit: got %b want 1", match); end
    endtask

    task automatic test_tp;
        logic [5:0] sels [4] = '{6'd1, 6'd0, 6'd60, 6'd61};
        logic       exps [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tp_sel = sels[i];
            tick(1);
            n_cmp++; if (tp_out !== exps[i]) begin n_err++; $display("FAIL tp_sel_%0d: got %b want %b", sels[i], tp_out, exps[i]); end
        end
    endtask

    task automatic test_saturate;
        logic both = 1'b0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        for (int i = 0; i < 18; i++) begin
            din[2] = ~din[2];
            for (int k = 0; k < 6; k++) begin tick(1); both |= |(rise & fall); end
            if (i == 13) begin
                n_cmp++; if (event_count !== 4'd14) begin n_err++; $display("FAIL sat_mid: got %0d want 14", event_count); end
            end
        end
        n_cmp++; if (event_count !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d want 15", event_count); end
        n_cmp++; if (both !== 1'b0) begin n_err++; $display("FAIL rise_fall_overlap: got %b want 0", both); end
    endtask

    task automatic test_reset_mid;
        logic saw = 1'b0;
        din = '0;
        tick(3);
        rst = 1'b1;
        tick(2);
        n_cmp++; if (state !== '0 || event_count !== 4'd0 || changed !== '0) begin n_err++; $display("FAIL rstmid_state: got %h %0d %h want 0", state, event_count, changed); end
        rst = 1'b0;
        tick(1);
        n_cmp++; if (match !== 1'b0 || tp_out !== 1'b0) begin n_err++; $display("FAIL rstmid_match_tp: got %b/%b want 0/0", match, tp_out); end
        saw = |(rise | fall);
        for (int i = 0; i < 10; i++) begin tick(1); saw |= |(rise | fall); end
        n_cmp++; if (saw !== 1'b0 || event_count !== 4'd0 || state !== '0) begin n_err++; $display("FAIL rstmid_edge: got saw %b count %0d state %h want 0", saw, event_count, state); end
    endtask

    initial begin
        test_reset;
        test_rise;
        test_fall;
        test_glitch;
        test_multi;
        test_clear_edge;
        test_match;
        test_tp;
        test_saturate;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
